// File: rtl/puf_challenge_sequencer.sv
// Sequencer for the arbiter PUF: walks an LFSR challenge sequence, pulses each challenge
// REPEATS times, majority-votes the samples and returns the packed word over valid/ready.
module puf_challenge_sequencer #(
    parameter int                  C_LENGTH    = 8,
    parameter int                  N_BITS      = 8,
    parameter int                  REPEATS     = 3,
    parameter int                  SETTLE_CYC  = 2,
    parameter int                  CAPTURE_CYC = 2,
    parameter logic [C_LENGTH-1:0] TAPS        = 8'hB8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [C_LENGTH-1:0]         seed,
    output logic                        busy,
    output logic [C_LENGTH-1:0]         ochallenge,
    output logic                        opulse,
    input  logic                        iresponse,
    output logic [N_BITS-1:0]           resp_data,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [$clog2(N_BITS+1)-1:0] unstable_cnt
);

    localparam int UW      = $clog2(N_BITS + 1);
    localparam int CYC_MAX = (SETTLE_CYC > CAPTURE_CYC) ? SETTLE_CYC : CAPTURE_CYC;
    localparam int CW      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int EW      = $clog2(REPEATS + 1);
    localparam int BW      = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [CW-1:0]       SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0]       CAPT_LAST   = CW'(CAPTURE_CYC - 1);
    localparam logic [EW-1:0]       EVAL_LAST   = EW'(REPEATS - 1);
    localparam logic [EW-1:0]       REP_ALL     = EW'(REPEATS);
    localparam logic [EW-1:0]       VOTE_HALF   = EW'(REPEATS / 2);
    localparam logic [BW-1:0]       BIT_LAST    = BW'(N_BITS - 1);
    localparam logic [UW-1:0]       UNST_MAX    = UW'(N_BITS);
    localparam logic [C_LENGTH-1:0] SEED_GUARD  = {{(C_LENGTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_PULSE  = 3'd2,
        ST_VOTE   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic [C_LENGTH-1:0] lfsr_step(input logic [C_LENGTH-1:0] cur);
        return {cur[C_LENGTH-2:0], ^(cur & TAPS)};
    endfunction

    function automatic logic vote_bit(input logic [EW-1:0] ones);
        return (ones > VOTE_HALF);
    endfunction

    // A bit is unstable when its samples disagreed at least once.
    function automatic logic vote_split(input logic [EW-1:0] ones);
        return (ones != {EW{1'b0}}) && (ones != REP_ALL);
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  accept_s;
    logic                  sample_s;
    logic                  vote_s;
    logic [CW-1:0]         cyc_cnt_r;
    logic [EW-1:0]         eval_cnt_r;
    logic [EW-1:0]         ones_cnt_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [C_LENGTH-1:0]   challenge_r;
    logic                  pulse_r;
    logic                  busy_r;
    logic [N_BITS-1:0]     data_r;
    logic                  valid_r;
    logic [UW-1:0]         unstable_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        sample_s    = 1'b0;
        vote_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SETTLE;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cyc_cnt_r == SETTLE_LAST) begin
                    state_nxt_s = ST_PULSE;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_PULSE: begin
                if (cyc_cnt_r == CAPT_LAST) begin
                    sample_s = 1'b1;
                    if (eval_cnt_r == EVAL_LAST) begin
                        state_nxt_s = ST_VOTE;
                    end else begin
                        state_nxt_s = ST_SETTLE;
                    end
                end else begin
                    state_nxt_s = ST_PULSE;
                end
            end
            ST_VOTE: begin
                vote_s = 1'b1;
                if (bit_cnt_r == BIT_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Counters, challenge LFSR, vote accumulation and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_r   <= {CW{1'b0}};
            eval_cnt_r  <= {EW{1'b0}};
            ones_cnt_r  <= {EW{1'b0}};
            bit_cnt_r   <= {BW{1'b0}};
            challenge_r <= {C_LENGTH{1'b0}};
            pulse_r     <= 1'b0;
            busy_r      <= 1'b0;
            data_r      <= {N_BITS{1'b0}};
            valid_r     <= 1'b0;
            unstable_r  <= {UW{1'b0}};
        end else begin
            if ((state_nxt_s == state_r) && ((state_r == ST_SETTLE) || (state_r == ST_PULSE))) begin
                cyc_cnt_r <= cyc_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cyc_cnt_r <= {CW{1'b0}};
            end

            if (accept_s) begin
                challenge_r <= (seed == {C_LENGTH{1'b0}}) ? SEED_GUARD : seed;
                eval_cnt_r  <= {EW{1'b0}};
                ones_cnt_r  <= {EW{1'b0}};
                bit_cnt_r   <= {BW{1'b0}};
                data_r      <= {N_BITS{1'b0}};
                unstable_r  <= {UW{1'b0}};
            end else if (sample_s) begin
                ones_cnt_r <= ones_cnt_r + EW'(iresponse);
                if (eval_cnt_r != EVAL_LAST) begin
                    eval_cnt_r <= eval_cnt_r + {{(EW-1){1'b0}}, 1'b1};
                end else begin
                    eval_cnt_r <= eval_cnt_r;
                end
            end else if (vote_s) begin
                data_r      <= {data_r[N_BITS-2:0], vote_bit(ones_cnt_r)};
                challenge_r <= lfsr_step(challenge_r);
                eval_cnt_r  <= {EW{1'b0}};
                ones_cnt_r  <= {EW{1'b0}};
                if (vote_split(ones_cnt_r) && (unstable_r != UNST_MAX)) begin
                    unstable_r <= unstable_r + {{(UW-1){1'b0}}, 1'b1};
                end else begin
                    unstable_r <= unstable_r;
                end
                if (bit_cnt_r != BIT_LAST) begin
                    bit_cnt_r <= bit_cnt_r + {{(BW-1){1'b0}}, 1'b1};
                end else begin
                    bit_cnt_r <= bit_cnt_r;
                end
            end else begin
                challenge_r <= challenge_r;
            end

            pulse_r <= (state_nxt_s == ST_PULSE);
            busy_r  <= (state_nxt_s != ST_IDLE);
            valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy         = busy_r;
    assign ochallenge   = challenge_r;
    assign opulse       = pulse_r;
    assign resp_data    = data_r;
    assign resp_valid   = valid_r;
    assign unstable_cnt = unstable_r;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer: latency, LFSR walk, voting, handshake and reset.
module tb_puf_challenge_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic       busy;
    logic [7:0] ochallenge;
    logic       opulse;
    logic       iresponse;
    logic [7:0] resp_data;
    logic       resp_valid;
    logic       resp_ready;
    logic [3:0] unstable_cnt;

    int   total = 0;
    int   bad   = 0;
    int   mode  = 0;
    logic resp_const = 1'b1;
    int   tog_cnt = 0;
    logic tog_base = 1'b0;
    logic seen;

    puf_challenge_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed),
        .busy         (busy),
        .ochallenge   (ochallenge),
        .opulse       (opulse),
        .iresponse    (iresponse),
        .resp_data    (resp_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .unstable_cnt (unstable_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every falling edge of opulse follows a sample; used to alternate the response.
    always @(negedge opulse) tog_cnt = tog_cnt + 1;

    assign iresponse = (mode == 1) ? ochallenge[0] :
                       (mode == 2) ? ~(tog_cnt[0] ^ tog_base) : resp_const;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [7:0] s);
        start = 1'b1;
        seed  = s;
        tick();
        start = 1'b0;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("hs_valid", {31'd0, resp_valid}, 32'd0);
        check("hs_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        seed       = 8'h00;
        resp_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pulse", {31'd0, opulse}, 32'd0);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_chal", {24'd0, ochallenge}, 32'h00);
        check("rst_data", {24'd0, resp_data}, 32'h00);
        check("rst_unst", {28'd0, unstable_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: constant 1 response, latency and pulse timing.
        mode = 0; resp_const = 1'b1;
        start_run(8'h01);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_chal0", {24'd0, ochallenge}, 32'h01);
        check("t1_pulse_e0", {31'd0, opulse}, 32'd0);
        tick();
        check("t1_pulse_e1", {31'd0, opulse}, 32'd0);
        tick();
        check("t1_pulse_e2", {31'd0, opulse}, 32'd1);
        repeat (101) tick();
        check("t1_valid_e103", {31'd0, resp_valid}, 32'd0);
        tick();
        check("t1_valid_e104", {31'd0, resp_valid}, 32'd1);
        check("t1_data", {24'd0, resp_data}, 32'hFF);
        check("t1_unst", {28'd0, unstable_cnt}, 32'd0);
        handshake();

        // 2: response follows ochallenge[0]; LFSR walk 01,02,04,08,11,23,47,8E.
        mode = 1;
        start_run(8'h01);
        repeat (52) tick();
        check("t2_chal_mid", {24'd0, ochallenge}, 32'h11);
        repeat (52) tick();
        check("t2_valid", {31'd0, resp_valid}, 32'd1);
        check("t2_data", {24'd0, resp_data}, 32'h8E);
        check("t2_unst", {28'd0, unstable_cnt}, 32'd0);
        check("t2_chal_end", {24'd0, ochallenge}, 32'h1C);
        handshake();

        // 3: alternating samples starting at 1.
        tog_base = tog_cnt[0];
        mode = 2;
        start_run(8'h5A);
        repeat (104) tick();
        check("t3_valid", {31'd0, resp_valid}, 32'd1);
        check("t3_data", {24'd0, resp_data}, 32'hAA);
        check("t3_unst", {28'd0, unstable_cnt}, 32'd8);
        handshake();

        // 4: zero seed is replaced by 01.
        mode = 1;
        start_run(8'h00);
        check("t4_chal0", {24'd0, ochallenge}, 32'h01);
        repeat (103) tick();
        check("t4_valid_e103", {31'd0, resp_valid}, 32'd0);
        tick();
        check("t4_valid", {31'd0, resp_valid}, 32'd1);
        check("t4_data", {24'd0, resp_data}, 32'h8E);

        // 5: stall in DONE with start pulses, then handshake with start high.
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            seed  = 8'h55;
            tick();
            check("t5_valid", {31'd0, resp_valid}, 32'd1);
            check("t5_data", {24'd0, resp_data}, 32'h8E);
            check("t5_chal", {24'd0, ochallenge}, 32'h1C);
        end
        start = 1'b1;
        resp_ready = 1'b1;
        tick();
        start = 1'b0;
        resp_ready = 1'b0;
        check("t5_hs_valid", {31'd0, resp_valid}, 32'd0);
        check("t5_hs_busy", {31'd0, busy}, 32'd0);
        check("t5_hs_data", {24'd0, resp_data}, 32'h8E);
        tick();
        check("t5_idle_busy", {31'd0, busy}, 32'd0);

        // 6: async reset while the pulse is high, then a clean run.
        mode = 0; resp_const = 1'b1;
        start_run(8'h01);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (opulse) seen = 1'b1;
            else tick();
        end
        check("t6_pulse_seen", {31'd0, seen}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_pulse", {31'd0, opulse}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_valid", {31'd0, resp_valid}, 32'd0);
        tick();
        rst = 1'b0;
        start_run(8'h01);
        repeat (103) tick();
        check("t6_valid_e103", {31'd0, resp_valid}, 32'd0);
        tick();
        check("t6_valid_e104", {31'd0, resp_valid}, 32'd1);
        check("t6_data", {24'd0, resp_data}, 32'hFF);
        check("t6_unst", {28'd0, unstable_cnt}, 32'd0);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
